// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter for the single-ported 64-bit data memory.
// It range-checks each address and returns the one-cycle-latency response to the requester that issued it.
module dmem_arbiter #(
  parameter int MEM_DEPTH = 124,
  parameter int ADDR_W    = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [63:0]       wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [63:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rerr0,
  output logic [63:0]       rdata0,
  output logic              rvalid1,
  output logic              rerr1,
  output logic [63:0]       rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [63:0]       mem_read_data
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  logic              last;
  logic              tag_valid;
  logic              tag_id;
  logic              tag_read;
  logic              tag_err;

  logic              granted;
  logic              sel_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [63:0]       sel_wdata;
  logic              legal;
  logic              access;

  // On contention the requester that was not granted last wins; grants are
  // forced low while reset is asserted.
  always_comb begin
    gnt0      = rst_n & req0 & (~req1 | last);
    gnt1      = rst_n & req1 & (~req0 | ~last);
    granted   = gnt0 | gnt1;
    sel_id    = gnt1;
    sel_we    = sel_id ? we1    : we0;
    sel_addr  = sel_id ? addr1  : addr0;
    sel_wdata = sel_id ? wdata1 : wdata0;
    legal     = sel_addr < DEPTH_A;
    access    = granted & legal;
  end

  always_comb begin
    mem_write      = access & sel_we;
    mem_read       = access & ~sel_we;
    mem_address    = access ? sel_addr  : '0;
    mem_write_data = access ? sel_wdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= 1'b1;
      tag_valid <= 1'b0;
      tag_id    <= 1'b0;
      tag_read  <= 1'b0;
      tag_err   <= 1'b0;
    end else begin
      if (granted) begin
        last <= sel_id;
      end
      tag_valid <= granted;
      tag_id    <= sel_id;
      tag_read  <= ~sel_we;
      tag_err   <= ~legal;
    end
  end

  // Memory read data is only forwarded for a good read; writes and errors
  // return zero data.
  always_comb begin
    rvalid0 = tag_valid & ~tag_id;
    rvalid1 = tag_valid & tag_id;
    rerr0   = rvalid0 & tag_err;
    rerr1   = rvalid1 & tag_err;
    rdata0  = (rvalid0 & tag_read & ~tag_err) ? mem_read_data : '0;
    rdata1  = (rvalid1 & tag_read & ~tag_err) ? mem_read_data : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural registered-read memory.
// Directed vectors push expected responses; a negedge monitor pops and compares.
module tb_dmem_arbiter;

  localparam int ADDR_W = 48;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, we0, req1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [63:0]       wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rerr0, rvalid1, rerr1;
  logic [63:0]       rdata0, rdata1;
  logic [ADDR_W-1:0] mem_address;
  logic [63:0]       mem_write_data;
  logic              mem_write, mem_read;
  logic [63:0]       mem_read_data;

  logic [63:0] mem [0:255];

  typedef struct {
    logic        port;
    logic        err;
    logic [63:0] data;
    string       name;
  } rsp_t;

  rsp_t rsp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_DEPTH(124), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rerr0(rerr0), .rdata0(rdata0),
    .rvalid1(rvalid1), .rerr1(rerr1), .rdata1(rdata1),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_read_data(mem_read_data)
  );

  // Behavioural single-port memory: write on the edge, registered read data.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'(i);
    mem_read_data = '0;
  end

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
    if (mem_read)  mem_read_data <= mem[mem_address[7:0]];
  end

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, actual, expected);
    end
  endtask

  // Response monitor: every rvalid must match the oldest outstanding grant.
  always @(negedge clk) begin
    if (rvalid0 || rvalid1) begin
      if (rsp_q.size() == 0) begin
        check_output("unexpected_rvalid", {62'b0, rvalid1, rvalid0}, 64'd0);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check_output({e.name, "_rvalid0"}, 64'(rvalid0), 64'(!e.port));
        check_output({e.name, "_rvalid1"}, 64'(rvalid1), 64'(e.port));
        check_output({e.name, "_rerr"}, 64'(e.port ? rerr1 : rerr0), 64'(e.err));
        check_output({e.name, "_rdata"}, e.port ? rdata1 : rdata0, e.data);
        check_output({e.name, "_rdata_other"}, e.port ? rdata0 : rdata1, 64'd0);
      end
    end
  end

  task automatic drive(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                       input logic [63:0] d0, input logic r1, input logic w1,
                       input logic [ADDR_W-1:0] a1, input logic [63:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  // One cycle of stimulus: drive after the edge, check grants/strobes mid-cycle,
  // and queue the expected response when a grant is expected.
  task automatic apply_stimulus(input string name,
                                input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                                input logic [63:0] d0,
                                input logic r1, input logic w1, input logic [ADDR_W-1:0] a1,
                                input logic [63:0] d1,
                                input logic eg0, input logic eg1,
                                input logic erd, input logic ewr,
                                input logic eerr, input logic [63:0] edata);
    rsp_t e;
    @(posedge clk);
    #1;
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    @(negedge clk);
    check_output({name, "_gnt0"}, 64'(gnt0), 64'(eg0));
    check_output({name, "_gnt1"}, 64'(gnt1), 64'(eg1));
    check_output({name, "_mem_read"}, 64'(mem_read), 64'(erd));
    check_output({name, "_mem_write"}, 64'(mem_write), 64'(ewr));
    if (eg0 || eg1) begin
      e.port = eg1; e.err = eerr; e.data = edata; e.name = name;
      rsp_q.push_back(e);
    end
  endtask

  task automatic idle(input string name);
    apply_stimulus(name, 0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 48'd2, '0, 0, 0, '0, '0);
    @(negedge clk);
    check_output("rst_gnt0", 64'(gnt0), 64'd0);
    check_output("rst_mem_read", 64'(mem_read), 64'd0);
    check_output("rst_rvalid0", 64'(rvalid0), 64'd0);
    check_output("rst_rdata0", rdata0, 64'd0);
    @(posedge clk);
    #1;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    rst_n = 1'b1;
    idle("idle_a");
    idle("idle_b");

    // Single port write then read of the same word.
    apply_stimulus("sp_write", 1, 1, 48'd5, 64'hDEAD_BEEF, 0, 0, '0, '0, 1, 0, 0, 1, 0, 64'd0);
    apply_stimulus("sp_read",  1, 0, 48'd5, '0, 0, 0, '0, '0, 1, 0, 1, 0, 0, 64'hDEAD_BEEF);
    apply_stimulus("p1_read",  0, 0, '0, '0, 1, 0, 48'd7, '0, 0, 1, 1, 0, 0, 64'd7);

    // Contention: last=1 here, so order is 0,1,0,1.
    apply_stimulus("ct0", 1, 0, 48'd3, '0, 1, 0, 48'd7, '0, 1, 0, 1, 0, 0, 64'd3);
    apply_stimulus("ct1", 1, 0, 48'd3, '0, 1, 0, 48'd7, '0, 0, 1, 1, 0, 0, 64'd7);
    apply_stimulus("ct2", 1, 0, 48'd3, '0, 1, 0, 48'd7, '0, 1, 0, 1, 0, 0, 64'd3);
    apply_stimulus("ct3", 1, 0, 48'd3, '0, 1, 0, 48'd7, '0, 0, 1, 1, 0, 0, 64'd7);

    // Range errors, including the first illegal address.
    apply_stimulus("err_rd", 0, 0, '0, '0, 1, 0, 48'd124, '0, 0, 1, 0, 0, 1, 64'd0);
    apply_stimulus("err_wr", 0, 0, '0, '0, 1, 1, 48'd200, 64'h1234, 0, 1, 0, 0, 1, 64'd0);
    apply_stimulus("edge_rd", 0, 0, '0, '0, 1, 0, 48'd123, '0, 0, 1, 1, 0, 0, 64'd123);

    // Write ack to port 0 coincides with a grant to port 1 reading the new data.
    apply_stimulus("sim_wr", 1, 1, 48'd10, 64'h55, 0, 0, '0, '0, 1, 0, 0, 1, 0, 64'd0);
    apply_stimulus("sim_rd", 0, 0, '0, '0, 1, 0, 48'd10, '0, 0, 1, 1, 0, 0, 64'h55);
    check_output("sim_rvalid0_with_gnt1", 64'(rvalid0 & gnt1), 64'd1);
    idle("idle_c");

    // Reset shortly after a read grant: response dropped, pointer restored.
    @(posedge clk);
    #1;
    drive(1, 0, 48'd3, '0, 0, 0, '0, '0);
    @(negedge clk);
    check_output("mr_gnt0", 64'(gnt0), 64'd1);
    @(posedge clk);
    #2;
    drive(0, 0, '0, '0, 0, 0, '0, '0);
    rst_n = 1'b0;
    #1;
    check_output("mr_rvalid0_now", 64'(rvalid0), 64'd0);
    check_output("mr_rdata0_now", rdata0, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle("idle_d");
    idle("idle_e");
    apply_stimulus("post_ct0", 1, 0, 48'd3, '0, 1, 0, 48'd7, '0, 1, 0, 1, 0, 0, 64'd3);
    apply_stimulus("post_ct1", 1, 0, 48'd3, '0, 1, 0, 48'd7, '0, 0, 1, 1, 0, 0, 64'd7);
    idle("idle_f");
    idle("idle_g");

    check_output("pending_responses", 64'(rsp_q.size()), 64'd0);
    check_output("mem124_untouched", mem[124], 64'd124);
    check_output("mem200_untouched", mem[200], 64'd200);
    check_output("mem5_written", mem[5], 64'hDEAD_BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
